// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
// Round-robin arbiter sharing one memory-controller burst port between two
// write channels (wr0, wr1) and two read channels (rd0, rd1). One burst is
// outstanding at a time. Controller handshakes and write data are routed
// combinationally to the granted channel only.
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BUSRT_BITS    = 10
) (
  input  logic                     mem_clk,
  input  logic                     rst,

  input  logic                     wr0_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr0_burst_len,
  input  logic [ADDR_BITS-1:0]     wr0_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] wr0_burst_data,
  output logic                     wr0_burst_data_req,
  output logic                     wr0_burst_finish,

  input  logic                     wr1_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr1_burst_len,
  input  logic [ADDR_BITS-1:0]     wr1_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] wr1_burst_data,
  output logic                     wr1_burst_data_req,
  output logic                     wr1_burst_finish,

  input  logic                     rd0_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd0_burst_len,
  input  logic [ADDR_BITS-1:0]     rd0_burst_addr,
  output logic                     rd0_burst_data_valid,
  output logic                     rd0_burst_finish,

  input  logic                     rd1_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd1_burst_len,
  input  logic [ADDR_BITS-1:0]     rd1_burst_addr,
  output logic                     rd1_burst_data_valid,
  output logic                     rd1_burst_finish,

  output logic                     wr_burst_req,
  output logic [BUSRT_BITS-1:0]    wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_data_req,
  input  logic                     wr_burst_finish,

  output logic                     rd_burst_req,
  output logic [BUSRT_BITS-1:0]    rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic                     rd_burst_finish,

  output logic [3:0]               grant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_LOCAL,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              grant_q, grant_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [BUSRT_BITS-1:0]   len_q, len_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic                    wr_req_q, wr_req_d;
  logic                    rd_req_q, rd_req_d;

  logic [3:0]              req_vec;
  logic [BUSRT_BITS-1:0]   req_len  [4];
  logic [ADDR_BITS-1:0]    req_addr [4];
  logic                    win_found;
  logic [1:0]              win_idx;
  logic [1:0]              cand;
  logic                    is_wr;
  logic                    in_burst;
  logic                    data_evt;
  logic                    fin_evt;
  logic                    local_fin;

  // Gather requester inputs into index order wr0, wr1, rd0, rd1.
  always_comb begin
    req_vec     = {rd1_burst_req, rd0_burst_req, wr1_burst_req, wr0_burst_req};
    req_len[0]  = wr0_burst_len;
    req_len[1]  = wr1_burst_len;
    req_len[2]  = rd0_burst_len;
    req_len[3]  = rd1_burst_len;
    req_addr[0] = wr0_burst_addr;
    req_addr[1] = wr1_burst_addr;
    req_addr[2] = rd0_burst_addr;
    req_addr[3] = rd1_burst_addr;
  end

  // Round-robin search starting at the pointer (one past the last grant).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req_vec[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Controller strobes qualified by the type of the current grant.
  always_comb begin
    is_wr     = |grant_q[1:0];
    in_burst  = (state_q == S_ISSUE) || (state_q == S_BUSY);
    data_evt  = in_burst && (is_wr ? wr_burst_data_req : rd_burst_data_valid);
    fin_evt   = in_burst && (is_wr ? wr_burst_finish : rd_burst_finish);
    local_fin = (state_q == S_LOCAL);
  end

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = 4'b0001 << win_idx;
          ptr_d   = win_idx + 2'd1;
          len_d   = req_len[win_idx];
          addr_d  = req_addr[win_idx];
          if (req_len[win_idx] == '0) begin
            state_d = S_LOCAL;
          end else begin
            state_d  = S_ISSUE;
            wr_req_d = ~win_idx[1];
            rd_req_d = win_idx[1];
          end
        end
      end
      S_ISSUE: begin
        // Finish together with (or ahead of) the first strobe closes the burst directly.
        if (fin_evt) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          grant_d  = '0;
          state_d  = S_GAP;
        end else if (data_evt) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fin_evt) begin
          grant_d = '0;
          state_d = S_GAP;
        end
      end
      S_LOCAL: begin
        grant_d = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        grant_d  = '0;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and registered controller-side outputs.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
    end
  end

  // Output drive and per-channel routing of controller strobes.
  always_comb begin
    grant         = grant_q;
    wr_burst_req  = wr_req_q;
    rd_burst_req  = rd_req_q;
    wr_burst_len  = len_q;
    rd_burst_len  = len_q;
    wr_burst_addr = addr_q;
    rd_burst_addr = addr_q;
    wr_burst_data = grant_q[1] ? wr1_burst_data : wr0_burst_data;

    wr0_burst_data_req   = in_burst & grant_q[0] & wr_burst_data_req;
    wr1_burst_data_req   = in_burst & grant_q[1] & wr_burst_data_req;
    rd0_burst_data_valid = in_burst & grant_q[2] & rd_burst_data_valid;
    rd1_burst_data_valid = in_burst & grant_q[3] & rd_burst_data_valid;

    wr0_burst_finish = grant_q[0] & ((in_burst & wr_burst_finish) | local_fin);
    wr1_burst_finish = grant_q[1] & ((in_burst & wr_burst_finish) | local_fin);
    rd0_burst_finish = grant_q[2] & ((in_burst & rd_burst_finish) | local_fin);
    rd1_burst_finish = grant_q[3] & ((in_burst & rd_burst_finish) | local_fin);
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Testbench for mem_burst_arbiter: directed scenarios with a small memory
// controller responder; expected grant/finish events go into a queue that a
// separate monitor pops and compares.
module tb_mem_burst_arbiter;

  localparam int DW = 32;
  localparam int AW = 23;
  localparam int LW = 10;
  localparam logic [DW-1:0] WR0_D = 32'h0000_AAAA;
  localparam logic [DW-1:0] WR1_D = 32'h5555_0000;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr0_burst_req, wr1_burst_req, rd0_burst_req, rd1_burst_req;
  logic [LW-1:0] wr0_burst_len, wr1_burst_len, rd0_burst_len, rd1_burst_len;
  logic [AW-1:0] wr0_burst_addr, wr1_burst_addr, rd0_burst_addr, rd1_burst_addr;
  logic [DW-1:0] wr0_burst_data, wr1_burst_data;
  logic          wr0_burst_data_req, wr1_burst_data_req;
  logic          wr0_burst_finish, wr1_burst_finish;
  logic          rd0_burst_data_valid, rd1_burst_data_valid;
  logic          rd0_burst_finish, rd1_burst_finish;
  logic          wr_burst_req, rd_burst_req;
  logic [LW-1:0] wr_burst_len, rd_burst_len;
  logic [AW-1:0] wr_burst_addr, rd_burst_addr;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_data_req, wr_burst_finish;
  logic          rd_burst_data_valid, rd_burst_finish;
  logic [3:0]    grant;

  typedef struct {
    bit            is_fin;
    logic [3:0]    vec;
    logic          wr_req;
    logic          rd_req;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   end_req = 0;
  bit   end_ack = 0;

  // controller responder state
  bit   ctl_active;
  bit   ctl_is_wr;
  int   ctl_len, ctl_cnt, ctl_wait;
  bit   inj_wr_fin, inj_wr_dreq;

  mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .wr0_burst_req(wr0_burst_req), .wr0_burst_len(wr0_burst_len), .wr0_burst_addr(wr0_burst_addr),
    .wr0_burst_data(wr0_burst_data), .wr0_burst_data_req(wr0_burst_data_req), .wr0_burst_finish(wr0_burst_finish),
    .wr1_burst_req(wr1_burst_req), .wr1_burst_len(wr1_burst_len), .wr1_burst_addr(wr1_burst_addr),
    .wr1_burst_data(wr1_burst_data), .wr1_burst_data_req(wr1_burst_data_req), .wr1_burst_finish(wr1_burst_finish),
    .rd0_burst_req(rd0_burst_req), .rd0_burst_len(rd0_burst_len), .rd0_burst_addr(rd0_burst_addr),
    .rd0_burst_data_valid(rd0_burst_data_valid), .rd0_burst_finish(rd0_burst_finish),
    .rd1_burst_req(rd1_burst_req), .rd1_burst_len(rd1_burst_len), .rd1_burst_addr(rd1_burst_addr),
    .rd1_burst_data_valid(rd1_burst_data_valid), .rd1_burst_finish(rd1_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .grant(grant)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_grant(input logic [3:0] vec, input logic wr, input logic rd,
                            input int len, input int addr, input int gap);
    exp_t e;
    e.is_fin = 1'b0; e.vec = vec; e.wr_req = wr; e.rd_req = rd;
    e.len = LW'(len); e.addr = AW'(addr); e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_fin(input logic [3:0] vec);
    exp_t e;
    e.is_fin = 1'b1; e.vec = vec; e.wr_req = 1'b0; e.rd_req = 1'b0;
    e.len = '0; e.addr = '0; e.gap = -1;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int ch, input int len, input int addr);
    case (ch)
      0: begin wr0_burst_req = 1'b1; wr0_burst_len = LW'(len); wr0_burst_addr = AW'(addr); end
      1: begin wr1_burst_req = 1'b1; wr1_burst_len = LW'(len); wr1_burst_addr = AW'(addr); end
      2: begin rd0_burst_req = 1'b1; rd0_burst_len = LW'(len); rd0_burst_addr = AW'(addr); end
      default: begin rd1_burst_req = 1'b1; rd1_burst_len = LW'(len); rd1_burst_addr = AW'(addr); end
    endcase
  endtask

  // One clock: channels drop req once served, controller responder advances.
  task automatic tick();
    logic c0, c1, c2, c3;
    @(negedge mem_clk);
    c0 = wr0_burst_data_req | wr0_burst_finish;
    c1 = wr1_burst_data_req | wr1_burst_finish;
    c2 = rd0_burst_data_valid | rd0_burst_finish;
    c3 = rd1_burst_data_valid | rd1_burst_finish;
    @(posedge mem_clk);
    #1;
    if (c0) wr0_burst_req = 1'b0;
    if (c1) wr1_burst_req = 1'b0;
    if (c2) rd0_burst_req = 1'b0;
    if (c3) rd1_burst_req = 1'b0;
    wr_burst_data_req   = inj_wr_dreq;
    wr_burst_finish     = inj_wr_fin;
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b0;
    inj_wr_dreq = 1'b0;
    inj_wr_fin  = 1'b0;
    if (rst) begin
      ctl_active = 1'b0;
    end else if (ctl_active) begin
      if (ctl_wait != 0) begin
        ctl_wait--;
      end else if (ctl_cnt < ctl_len) begin
        if (ctl_is_wr) wr_burst_data_req = 1'b1;
        else rd_burst_data_valid = 1'b1;
        ctl_cnt++;
      end else begin
        if (ctl_is_wr) wr_burst_finish = 1'b1;
        else rd_burst_finish = 1'b1;
        ctl_active = 1'b0;
      end
    end else if (wr_burst_req || rd_burst_req) begin
      ctl_active = 1'b1;
      ctl_is_wr  = wr_burst_req;
      ctl_len    = wr_burst_req ? int'(wr_burst_len) : int'(rd_burst_len);
      ctl_wait   = 1;
      ctl_cnt    = 0;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    ctl_active = 1'b0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    wr0_burst_req = 1'b0; wr1_burst_req = 1'b0; rd0_burst_req = 1'b0; rd1_burst_req = 1'b0;
    tick_n(n);
    rst = 1'b0;
  endtask

  // Stimulus: directed scenarios, expected events pushed as issued.
  initial begin
    wr0_burst_req = 0; wr1_burst_req = 0; rd0_burst_req = 0; rd1_burst_req = 0;
    wr0_burst_len = '0; wr1_burst_len = '0; rd0_burst_len = '0; rd1_burst_len = '0;
    wr0_burst_addr = '0; wr1_burst_addr = '0; rd0_burst_addr = '0; rd1_burst_addr = '0;
    wr0_burst_data = WR0_D; wr1_burst_data = WR1_D;
    wr_burst_data_req = 0; wr_burst_finish = 0; rd_burst_data_valid = 0; rd_burst_finish = 0;
    ctl_active = 0; ctl_is_wr = 0; ctl_len = 0; ctl_cnt = 0; ctl_wait = 0;
    inj_wr_fin = 0; inj_wr_dreq = 0;
    #2;
    apply_reset(3);

    // 1: single long write burst from wr0
    push_grant(4'b0001, 1, 0, 256, 'h100, -1);
    push_fin(4'b0001);
    set_req(0, 256, 'h100);
    tick_n(275);

    // 2: all four request together after reset -> wr0, wr1, rd0, rd1
    apply_reset(2);
    push_grant(4'b0001, 1, 0, 4, 'h10, -1); push_fin(4'b0001);
    push_grant(4'b0010, 1, 0, 3, 'h20, 3);  push_fin(4'b0010);
    push_grant(4'b0100, 0, 1, 2, 'h30, 3);  push_fin(4'b0100);
    push_grant(4'b1000, 0, 1, 5, 'h40, 3);  push_fin(4'b1000);
    set_req(0, 4, 'h10); set_req(1, 3, 'h20); set_req(2, 2, 'h30); set_req(3, 5, 'h40);
    tick_n(60);

    // 3: rd0 arrives while wr1 burst is running
    push_grant(4'b0010, 1, 0, 8, 'h2000, -1); push_fin(4'b0010);
    push_grant(4'b0100, 0, 1, 2, 'h3000, 3);  push_fin(4'b0100);
    set_req(1, 8, 'h2000);
    tick_n(5);
    set_req(2, 2, 'h3000);
    tick_n(30);

    // 4: zero-length rd1, then pointer must favour wr0 over rd1
    push_grant(4'b1000, 0, 0, 0, 'h44, -1); push_fin(4'b1000);
    set_req(3, 0, 'h44);
    tick_n(6);
    push_grant(4'b0001, 1, 0, 2, 'h500, -1); push_fin(4'b0001);
    push_grant(4'b1000, 0, 1, 1, 'h600, 3);  push_fin(4'b1000);
    set_req(0, 2, 'h500); set_req(3, 1, 'h600);
    tick_n(30);

    // 5: reset in the middle of an rd0 burst; wr0 wins over rd1 afterwards
    push_grant(4'b0100, 0, 1, 20, 'h7000, -1);
    set_req(2, 20, 'h7000);
    tick_n(8);
    apply_reset(2);
    push_grant(4'b0001, 1, 0, 3, 'h800, -1); push_fin(4'b0001);
    push_grant(4'b1000, 0, 1, 2, 'h900, 3);  push_fin(4'b1000);
    set_req(0, 3, 'h800); set_req(3, 2, 'h900);
    tick_n(30);

    // 6: stray write strobes while rd0 is granted
    push_grant(4'b0100, 0, 1, 6, 'hA00, -1); push_fin(4'b0100);
    set_req(2, 6, 'hA00);
    tick_n(4);
    inj_wr_fin = 1'b1; inj_wr_dreq = 1'b1;
    tick_n(25);

    tick_n(5);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_ack; i++) @(negedge mem_clk);
    #1;
    if (!end_ack) begin
      $display("FAIL end_handshake: monitor did not acknowledge");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  // Monitor: pops expected events as the DUT presents grants and finishes.
  initial begin
    exp_t       e;
    logic [3:0] prev_grant, exp_g, fin_vec, dvec, exp_dvec;
    logic       prev_wd, prev_rv;
    int         last_fin_cyc;
    prev_grant = '0; exp_g = '0; prev_wd = 0; prev_rv = 0; last_fin_cyc = 0;
    forever begin
      @(negedge mem_clk);
      cyc++;
      if (rst) begin
        check("rst_ctrl", 64'({grant, wr_burst_req, rd_burst_req,
                               wr0_burst_data_req, wr1_burst_data_req,
                               rd0_burst_data_valid, rd1_burst_data_valid,
                               wr0_burst_finish, wr1_burst_finish,
                               rd0_burst_finish, rd1_burst_finish}), 64'd0);
        check("rst_wr_bus", 64'({wr_burst_len, wr_burst_addr}), 64'd0);
        check("rst_rd_bus", 64'({rd_burst_len, rd_burst_addr}), 64'd0);
        prev_grant = '0; exp_g = '0; prev_wd = 0; prev_rv = 0;
      end else begin
        if (prev_wd) check("wr_req_drop", 64'(wr_burst_req), 64'd0);
        if (prev_rv) check("rd_req_drop", 64'(rd_burst_req), 64'd0);
        if (wr_burst_req || rd_burst_req)
          check("req_exclusive", 64'(wr_burst_req & rd_burst_req), 64'd0);

        if (grant != 4'd0 && prev_grant == 4'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 64'(grant), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("grant", 64'({1'b0, grant}), 64'({e.is_fin, e.vec}));
            if (!e.is_fin) begin
              exp_g = e.vec;
              check("grant_wr_req", 64'(wr_burst_req), 64'(e.wr_req));
              check("grant_rd_req", 64'(rd_burst_req), 64'(e.rd_req));
              if (e.wr_req) check("wr_len_addr", 64'({wr_burst_len, wr_burst_addr}), 64'({e.len, e.addr}));
              if (e.rd_req) check("rd_len_addr", 64'({rd_burst_len, rd_burst_addr}), 64'({e.len, e.addr}));
              if (e.gap >= 0) check("grant_gap", 64'(cyc - last_fin_cyc), 64'(e.gap));
            end
          end
        end

        dvec = {rd1_burst_data_valid, rd0_burst_data_valid, wr1_burst_data_req, wr0_burst_data_req};
        exp_dvec = {rd_burst_data_valid & exp_g[3], rd_burst_data_valid & exp_g[2],
                    wr_burst_data_req & exp_g[1], wr_burst_data_req & exp_g[0]};
        if (wr_burst_data_req || rd_burst_data_valid || dvec != 4'd0)
          check("data_route", 64'(dvec), 64'(exp_dvec));
        if (wr_burst_data_req)
          check("wr_data_mux", 64'(wr_burst_data), 64'(exp_g[1] ? WR1_D : WR0_D));
        prev_wd = wr_burst_data_req & (|exp_g[1:0]);
        prev_rv = rd_burst_data_valid & (|exp_g[3:2]);

        fin_vec = {rd1_burst_finish, rd0_burst_finish, wr1_burst_finish, wr0_burst_finish};
        if (fin_vec != 4'd0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_finish", 64'(fin_vec), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("finish", 64'({1'b1, fin_vec}), 64'({e.is_fin, e.vec}));
            if (e.is_fin) exp_g = '0;
          end
          last_fin_cyc = cyc;
        end
        prev_grant = grant;
      end
      if (end_req && !end_ack) begin
        check("leftover_events", 64'(exp_q.size()), 64'd0);
        end_ack = 1'b1;
      end
    end
  end

endmodule
